// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data memory: access sizes, controller states, response record
// and the load-extension helper used on the read path.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_RSV = 2'b11
   } size_e;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_e;

   typedef struct packed {
      logic        vld;
      logic        err;
      logic [31:0] dat;
   } rsp_t;

   // Lane(s) are shifted down to bit 0 first; half loads only ever see lane 0 or 2.
   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                            input logic [1:0] size, input logic sgn);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         SZ_B:    load_ext = {{24{sgn & sh[7]}}, sh[7:0]};
         SZ_H:    load_ext = {{16{sgn & sh[15]}}, sh[15:0]};
         default: load_ext = word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bytearray.sv
// DEPTH x 32-bit storage split into four byte lanes; 1-cycle synchronous read, byte-enable write.
// Read returns the pre-write contents when read and write hit the same word on the same edge.
module dmem_bytearray #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] i_addr,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] r_lane [DEPTH];
      logic [7:0] r_q;

      always_ff @(posedge clk) begin
         if (i_be[g]) begin
            r_lane[i_addr] <= i_wdata[8*g +: 8];
         end
         r_q <= r_lane[i_addr];
      end

      assign o_rdata[8*g +: 8] = r_q;
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable data memory: byte/half/word access, load extension, error flagging, zero-fill sweep.
// Response READ_LAT cycles after accept, never stalled; requests are refused while the sweep runs.
module dmem_ctrl
   import mips_mem_pkg::*;
#(
   parameter int DEPTH    = 1024,
   parameter int READ_LAT = 1,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_req,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   state_e        r_state;
   state_e        w_state_nxt;
   logic [AW-1:0] r_cnt;

   logic          w_acc;
   logic          w_err;
   logic [1:0]    w_lane;
   logic [AW-1:0] w_idx;

   logic [AW-1:0] w_mem_addr;
   logic [3:0]    w_mem_be;
   logic [31:0]   w_mem_wdata;
   logic [31:0]   w_mem_rdata;

   logic          r_s1_vld;
   logic          r_s1_err;
   logic          r_s1_ld;
   logic          r_s1_sgn;
   logic [1:0]    r_s1_lane;
   logic [1:0]    r_s1_size;
   rsp_t          w_s1;
   rsp_t          w_last;

   assign w_acc  = req_valid && req_ready;
   assign w_lane = req_addr[1:0];
   assign w_idx  = req_addr[AW+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CLEAR:   if (r_cnt == LAST_IDX) w_state_nxt = IDLE;
         IDLE:    if (clear_req) w_state_nxt = CLEAR;
         default: w_state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      req_ready = 1'b0;
      busy      = 1'b1;
      if (r_state == IDLE) begin
         req_ready = 1'b1;
         busy      = 1'b0;
      end
   end

   // Counter is zeroed on the way into CLEAR so a requested sweep starts at word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (r_state == CLEAR) begin
         r_cnt <= r_cnt + AW'(1);
      end else if (clear_req) begin
         r_cnt <= '0;
      end
   end

   always_comb begin
      w_err = 1'b0;
      case (req_size)
         SZ_H:    w_err = req_addr[0];
         SZ_W:    w_err = |req_addr[1:0];
         SZ_RSV:  w_err = 1'b1;
         default: w_err = 1'b0;
      endcase
      if ((req_addr >> (AW + 2)) != 32'd0) begin
         w_err = 1'b1;
      end
   end

   // Store data is replicated across lanes so the byte enables alone select the target bytes.
   always_comb begin
      w_mem_addr  = w_idx;
      w_mem_be    = 4'b0000;
      w_mem_wdata = 32'd0;
      if (r_state == CLEAR) begin
         w_mem_addr = r_cnt;
         w_mem_be   = 4'b1111;
      end else if (w_acc && req_we && !w_err) begin
         case (req_size)
            SZ_B: begin
               w_mem_be    = 4'b0001 << w_lane;
               w_mem_wdata = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
               w_mem_be    = 4'b0011 << w_lane;
               w_mem_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
               w_mem_be    = 4'b1111;
               w_mem_wdata = req_wdata;
            end
         endcase
      end
   end

   dmem_bytearray #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .i_addr  (w_mem_addr),
      .i_be    (w_mem_be),
      .i_wdata (w_mem_wdata),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld  <= 1'b0;
         r_s1_err  <= 1'b0;
         r_s1_ld   <= 1'b0;
         r_s1_sgn  <= 1'b0;
         r_s1_lane <= 2'b00;
         r_s1_size <= 2'b00;
      end else begin
         r_s1_vld <= w_acc;
         if (w_acc) begin
            r_s1_err  <= w_err;
            r_s1_ld   <= !req_we && !w_err;
            r_s1_sgn  <= req_signed;
            r_s1_lane <= w_lane;
            r_s1_size <= req_size;
         end
      end
   end

   // Stage 1: the array's read register plus captured request attributes, extended here.
   always_comb begin
      w_s1 = '0;
      if (r_s1_vld) begin
         w_s1.vld = 1'b1;
         w_s1.err = r_s1_err;
         if (r_s1_ld) begin
            w_s1.dat = load_ext(w_mem_rdata, r_s1_lane, r_s1_size, r_s1_sgn);
         end
      end
   end

   if (READ_LAT == 1) begin : g_lat1
      assign w_last = w_s1;
   end else begin : g_latn
      rsp_t r_pipe [READ_LAT-1];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < READ_LAT - 1; i++) begin
               r_pipe[i] <= '0;
            end
         end else begin
            r_pipe[0] <= w_s1;
            for (int i = 1; i < READ_LAT - 1; i++) begin
               r_pipe[i] <= r_pipe[i-1];
            end
         end
      end

      assign w_last = r_pipe[READ_LAT-2];
   end

   assign rsp_valid = w_last.vld;
   assign rsp_err   = w_last.err;
   assign rsp_rdata = w_last.dat;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: a READ_LAT=3 and a READ_LAT=1 instance (DEPTH=16) driven by the same requests.
module tb_dmem_ctrl;
   import mips_mem_pkg::*;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic        clear_req = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we    = 1'b0;
   logic [1:0]  req_size  = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr  = 32'd0;
   logic [31:0] req_wdata = 32'd0;

   logic        m_ready, m_vld, m_err, m_busy;
   logic [31:0] m_dat;
   logic        a_ready, a_vld, a_err, a_busy;
   logic [31:0] a_dat;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH(16), .READ_LAT(3)) u_main (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .req_valid(req_valid), .req_ready(m_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(m_vld), .rsp_rdata(m_dat), .rsp_err(m_err), .busy(m_busy)
   );

   dmem_ctrl #(.DEPTH(16), .READ_LAT(1)) u_aux (
      .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .req_valid(req_valid), .req_ready(a_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(a_vld), .rsp_rdata(a_dat), .rsp_err(a_err), .busy(a_busy)
   );

   // Issues one request and reports, per instance, the first response and its distance in cycles.
   task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] addr,
                        input logic [31:0] wd, output int lm, output logic [31:0] dm, output logic em,
                        output int la, output logic [31:0] da, output logic ea);
      lm = 0; dm = 32'd0; em = 1'b0;
      la = 0; da = 32'd0; ea = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
      @(posedge clk);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         req_valid = 1'b0;
         if (m_vld && lm == 0) begin lm = n; dm = m_dat; em = m_err; end
         if (a_vld && la == 0) begin la = n; da = a_dat; ea = a_err; end
      end
   endtask

   task automatic test_reset();
      int bcnt, bad_rdy;
      int lm, la;
      logic [31:0] dm, da;
      logic em, ea;
      #2 rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (m_busy !== 1'b1 || m_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctl_main: busy=%b ready=%b, want busy=1 ready=0", m_busy, m_ready);
      end
      n_checks++;
      if (m_vld !== 1'b0 || m_err !== 1'b0 || m_dat !== 32'd0) begin
         n_fail++; $display("FAIL reset_rsp_main: vld=%b err=%b dat=%h, want 0 0 0", m_vld, m_err, m_dat);
      end
      n_checks++;
      if (a_busy !== 1'b1 || a_ready !== 1'b0 || a_vld !== 1'b0 || a_dat !== 32'd0 || a_err !== 1'b0) begin
         n_fail++; $display("FAIL reset_aux: busy=%b ready=%b vld=%b err=%b dat=%h, want 1 0 0 0 0",
                            a_busy, a_ready, a_vld, a_err, a_dat);
      end
      rst_n = 1'b1;
      bcnt = 0; bad_rdy = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_busy) bcnt++;
         if (m_ready === m_busy) bad_rdy++;
         @(negedge clk);
      end
      n_checks++;
      if (bcnt != 16 || bad_rdy != 0) begin
         n_fail++; $display("FAIL reset_sweep_len: busy_cycles=%0d ready_conflicts=%0d, want 16 and 0", bcnt, bad_rdy);
      end
      n_checks++;
      if (m_ready !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: ready=%b/%b abusy=%b, want 1/1 0", m_ready, a_ready, a_busy);
      end
      issue(1'b0, SZ_W, 1'b0, 32'h3C, 32'd0, lm, dm, em, la, da, ea);
      n_checks++;
      if (lm != 3 || dm !== 32'd0 || em !== 1'b0 || la != 1 || da !== 32'd0 || ea !== 1'b0) begin
         n_fail++; $display("FAIL lw_3c_after_reset: lat=%0d/%0d dat=%h/%h err=%b/%b, want 3/1 0/0 0/0",
                            lm, la, dm, da, em, ea);
      end
   endtask

   task automatic test_byte_lanes();
      logic [1:0]  sz  [8] = '{SZ_W, SZ_B, SZ_W, SZ_B, SZ_B, SZ_H, SZ_H, SZ_H};
      logic        we  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        sg  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] ad  [8] = '{32'h8, 32'h9, 32'h8, 32'h9, 32'h9, 32'hA, 32'h8, 32'h8};
      logic [31:0] wd  [8] = '{32'h11223344, 32'h000000AA, 0, 0, 0, 0, 0, 0};
      logic [31:0] exp [8] = '{32'h0, 32'h0, 32'h1122AA44, 32'hFFFFFFAA, 32'h000000AA,
                               32'h00001122, 32'hFFFFAA44, 32'h0000AA44};
      int lm, la;
      logic [31:0] dm, da;
      logic em, ea;
      for (int k = 0; k < 8; k++) begin
         issue(we[k], sz[k], sg[k], ad[k], wd[k], lm, dm, em, la, da, ea);
         n_checks++;
         if (lm != 3 || la != 1 || dm !== exp[k] || da !== exp[k] || em !== 1'b0 || ea !== 1'b0) begin
            n_fail++; $display("FAIL lanes_%0d addr=%h: lat=%0d/%0d dat=%h/%h err=%b/%b, want 3/1 %h 0",
                               k, ad[k], lm, la, dm, da, em, ea, exp[k]);
         end
      end
   endtask

   task automatic test_errors();
      logic [1:0]  sz  [7] = '{SZ_H, SZ_W, SZ_W, SZ_RSV, SZ_W, SZ_W, SZ_W};
      logic        we  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] ad  [7] = '{32'h5, 32'h6, 32'h4, 32'h0, 32'h40, 32'h40, 32'h0};
      logic [31:0] wd  [7] = '{0, 32'hDEADBEEF, 0, 0, 0, 32'h12345678, 0};
      logic        xe  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      int lm, la;
      logic [31:0] dm, da;
      logic em, ea;
      for (int k = 0; k < 7; k++) begin
         issue(we[k], sz[k], 1'b1, ad[k], wd[k], lm, dm, em, la, da, ea);
         n_checks++;
         if (lm != 3 || la != 1 || dm !== 32'd0 || da !== 32'd0 || em !== xe[k] || ea !== xe[k]) begin
            n_fail++; $display("FAIL err_%0d addr=%h: lat=%0d/%0d dat=%h/%h err=%b/%b, want 3/1 0 err=%b",
                               k, ad[k], lm, la, dm, da, em, ea, xe[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0]  mv, av;
      logic [31:0] md [9];
      logic [31:0] ad [9];
      mv = '0; av = '0;
      for (int i = 0; i < 9; i++) begin md[i] = 32'hX; ad[i] = 32'hX; end
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h0; req_wdata = 32'd5;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         mv[n] = m_vld; md[n] = m_dat;
         av[n] = a_vld; ad[n] = a_dat;
         if (n == 1) begin req_we = 1'b0; req_addr = 32'h0; end
         if (n == 2) req_addr = 32'h4;
         if (n == 3) req_valid = 1'b0;
      end
      n_checks++;
      if (mv !== 9'b000111000 || av !== 9'b000001110) begin
         n_fail++; $display("FAIL b2b_strobes: main=%b aux=%b, want 000111000 000001110", mv, av);
      end
      n_checks++;
      if (md[3] !== 32'd0 || md[4] !== 32'd5 || md[5] !== 32'd0) begin
         n_fail++; $display("FAIL b2b_data_main: %h %h %h, want 0 5 0", md[3], md[4], md[5]);
      end
      n_checks++;
      if (ad[1] !== 32'd0 || ad[2] !== 32'd5 || ad[3] !== 32'd0) begin
         n_fail++; $display("FAIL b2b_data_aux: %h %h %h, want 0 5 0", ad[1], ad[2], ad[3]);
      end
   endtask

   task automatic test_clear();
      int lm, la, bcnt;
      logic [31:0] dm, da;
      logic em, ea;
      issue(1'b1, SZ_W, 1'b0, 32'h0, 32'hFFFFFFFF, lm, dm, em, la, da, ea);
      lm = 0; la = 0; bcnt = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h0; clear_req = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (m_busy) bcnt++;
         if (m_vld && lm == 0) begin lm = n; dm = m_dat; end
         if (a_vld && la == 0) begin la = n; da = a_dat; end
         if (n == 1) begin req_valid = 1'b0; clear_req = 1'b0; end
         if (n == 5) clear_req = 1'b1;
         if (n == 6) clear_req = 1'b0;
      end
      n_checks++;
      if (lm != 3 || la != 1 || dm !== 32'hFFFFFFFF || da !== 32'hFFFFFFFF) begin
         n_fail++; $display("FAIL clear_inflight: lat=%0d/%0d dat=%h/%h, want 3/1 ffffffff", lm, la, dm, da);
      end
      n_checks++;
      if (bcnt != 16) begin
         n_fail++; $display("FAIL clear_busy_len: busy_cycles=%0d, want 16", bcnt);
      end
      issue(1'b0, SZ_W, 1'b0, 32'h0, 32'd0, lm, dm, em, la, da, ea);
      n_checks++;
      if (lm != 3 || la != 1 || dm !== 32'd0 || da !== 32'd0 || em !== 1'b0) begin
         n_fail++; $display("FAIL clear_zeroed: lat=%0d/%0d dat=%h/%h err=%b, want 3/1 0 0", lm, la, dm, da, em);
      end
   endtask

   task automatic test_reset_mid();
      int lm, la, bcnt, vcnt;
      logic [31:0] dm, da;
      logic em, ea;
      issue(1'b1, SZ_W, 1'b0, 32'h8, 32'hCAFEF00D, lm, dm, em, la, da, ea);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_addr = 32'h8;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (m_busy !== 1'b1 || m_vld !== 1'b0) begin
         n_fail++; $display("FAIL midreset_async: busy=%b vld=%b, want 1 0", m_busy, m_vld);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bcnt = 0; vcnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (m_busy) bcnt++;
         if (m_vld) vcnt++;
         @(negedge clk);
      end
      n_checks++;
      if (vcnt != 0 || bcnt != 16) begin
         n_fail++; $display("FAIL midreset_drop: rsp_pulses=%0d busy_cycles=%0d, want 0 16", vcnt, bcnt);
      end
      issue(1'b0, SZ_W, 1'b0, 32'h8, 32'd0, lm, dm, em, la, da, ea);
      n_checks++;
      if (lm != 3 || la != 1 || dm !== 32'd0 || da !== 32'd0) begin
         n_fail++; $display("FAIL midreset_zeroed: lat=%0d/%0d dat=%h/%h, want 3/1 0", lm, la, dm, da);
      end
   endtask

   initial begin
      test_reset();
      test_byte_lanes();
      test_errors();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at 200000, want completion");
      $fatal(1, "timeout");
   end

endmodule
